// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
//
// Boot-time program loader for the 8-bit microprocessor. A program image
// arrives as a byte stream over a valid/ready handshake and is written into
// the processor RAM write port. The processor is held in reset (cpu_hold)
// until the complete image has been written (and, when enabled, verified).
//
// Frame on the stream: LEN, then LEN payload bytes, then an optional CHK.
// LEN = 0 stands for 2**ADDR_W payload bytes.
//
// Build option:
//   LOADER_CHECKSUM_EN  defined     : a CHK byte follows the payload; the
//                                     image is accepted only when
//                                     (sum(payload) + CHK) mod 2**DATA_W == 0,
//                                     otherwise the loader parks in ERROR.
//                       not defined : no CHK byte, no running sum, LOAD goes
//                                     straight to DONE and err is tied low.
//
// Parameters:
//   ADDR_W     RAM address width (also the payload counter width)
//   DATA_W     RAM data / stream byte width
//   BASE_ADDR  RAM address that receives the first payload byte
//
// Ports:
//   clk       in   rising-edge system clock
//   reset     in   asynchronous, active-low reset
//   start     in   one-cycle pulse: begin/restart a load (ignored mid-frame)
//   rx_data   in   stream byte
//   rx_valid  in   rx_data valid
//   rx_ready  out  loader accepts a byte this cycle (registered)
//   ram_addr  out  RAM write address (registered, holds when idle)
//   ram_data  out  RAM write data (registered, holds when idle)
//   ram_wren  out  RAM write strobe, one-cycle pulse per payload byte
//   cpu_hold  out  1 = processor kept in reset
//   done      out  image loaded; level until next start
//   err       out  checksum mismatch; level until next start
// ---------------------------------------------------------------------------
module prog_loader #(
  parameter int          ADDR_W    = 8,
  parameter int          DATA_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_LOAD,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  // LEN is a stream byte; the counter is address-wide. A LEN of zero loads
  // a zero counter, which the decrement-until-1->0 exit rule turns into a
  // full 2**ADDR_W byte transfer without any special casing.
  function automatic logic [ADDR_W-1:0] len_to_count(input logic [DATA_W-1:0] len);
    return ADDR_W'(len);
  endfunction

  // rx_ready is derived from the state being entered so that it is a clean
  // register output aligned with state_q.
  function automatic logic state_takes_bytes(input state_t s);
    return (s == S_HDR) || (s == S_LOAD) || (s == S_CHECK);
  endfunction

  state_t            state_q,    state_d;
  logic [ADDR_W-1:0] count_q,    count_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_data_q, ram_data_d;
  logic              ram_wren_q, ram_wren_d;
  logic              rx_ready_q, rx_ready_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              done_q,     done_d;
`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q,      sum_d;
  logic [DATA_W-1:0] chk_total;
  logic              err_q,      err_d;
`endif

  logic accept;

  assign accept = rx_valid & rx_ready_q;

`ifdef LOADER_CHECKSUM_EN
  assign chk_total = sum_q + rx_data;
`endif

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    ram_wren_d = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    sum_d      = sum_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_HDR;
      end

      S_HDR: begin
        if (accept) begin
          count_d = len_to_count(rx_data);
          // Pre-decrement so the first payload byte lands on BASE.
          ram_addr_d = BASE - 1'b1;
`ifdef LOADER_CHECKSUM_EN
          sum_d = '0;
`endif
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        if (accept) begin
          ram_addr_d = ram_addr_q + 1'b1;
          ram_data_d = rx_data;
          ram_wren_d = 1'b1;
          count_d    = count_q - 1'b1;
`ifdef LOADER_CHECKSUM_EN
          sum_d = sum_q + rx_data;
          if (count_q == ADDR_W'(1)) state_d = S_CHECK;
`else
          if (count_q == ADDR_W'(1)) state_d = S_DONE;
`endif
        end
      end

`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (accept) begin
          state_d = (chk_total == '0) ? S_DONE : S_ERROR;
        end
      end

      S_ERROR: begin
        if (start) state_d = S_HDR;
      end
`endif

      S_DONE: begin
        if (start) state_d = S_HDR;
      end

      default: state_d = S_IDLE;
    endcase

    // Status outputs are functions of the next state, so done rises and
    // cpu_hold falls on the very same edge, and both clear together on
    // the start edge that re-enters HDR.
    rx_ready_d = state_takes_bytes(state_d);
    done_d     = (state_d == S_DONE);
    cpu_hold_d = (state_d != S_DONE);
`ifdef LOADER_CHECKSUM_EN
    err_d      = (state_d == S_ERROR);
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      ram_addr_q <= BASE;
      ram_data_q <= '0;
      ram_wren_q <= 1'b0;
      rx_ready_q <= 1'b0;
      cpu_hold_q <= 1'b1;
      done_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
      ram_wren_q <= ram_wren_d;
      rx_ready_q <= rx_ready_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
      err_q      <= err_d;
`endif
    end
  end

  assign rx_ready = rx_ready_q;
  assign ram_addr = ram_addr_q;
  assign ram_data = ram_data_q;
  assign ram_wren = ram_wren_q;
  assign cpu_hold = cpu_hold_q;
  assign done     = done_q;
`ifdef LOADER_CHECKSUM_EN
  assign err      = err_q;
`else
  assign err      = 1'b0;
`endif

endmodule
